// File: rtl/muldiv_unit.sv
// Sequential signed 32x32 multiply/divide: radix-2 Booth multiply, restoring divide on
// magnitudes with a final sign fix. One bit per cycle, 64-bit result held on zhi_out/zlo_out.
module muldiv_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] y_in,
  input  logic [31:0] bus_in,
  output logic [31:0] zhi_out,
  output logic [31:0] zlo_out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t      state, state_nxt;
  logic        op_r, a_neg, b_neg, dz, qm1;
  logic [32:0] acc;   // MUL: A with a guard bit; DIV: remainder R
  logic [31:0] q, m, d;
  logic [5:0]  cnt;

  logic [32:0] m_ext, booth_sum, r_sh;
  logic [33:0] trial;
  logic [31:0] quot, rem;

  // The guard bit keeps A exact when M is the most negative value.
  always_comb begin
    m_ext     = {m[31], m};
    booth_sum = acc;
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  always_comb begin
    r_sh  = {acc[31:0], q[31]};
    trial = {1'b0, r_sh} - {2'b00, d};
    quot  = (a_neg ^ b_neg) ? (32'd0 - q) : q;
    rem   = a_neg ? (32'd0 - acc[31:0]) : acc[31:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op ? ((bus_in == 32'd0) ? FIN : DIV) : MUL;
      MUL,
      DIV:     if (cnt == 6'd31) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_r        <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dz          <= 1'b0;
      qm1         <= 1'b0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      d           <= '0;
      cnt         <= '0;
      zhi_out     <= '0;
      zlo_out     <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r        <= op;
          cnt         <= '0;
          div_by_zero <= 1'b0;
          dz          <= op && (bus_in == 32'd0);
          m           <= y_in;
          acc         <= '0;
          qm1         <= 1'b0;
          a_neg       <= y_in[31];
          b_neg       <= bus_in[31];
          if (op) begin
            q <= y_in[31]   ? (32'd0 - y_in)   : y_in;
            d <= bus_in[31] ? (32'd0 - bus_in) : bus_in;
          end else begin
            q <= bus_in;
          end
        end
        MUL: begin
          acc <= {booth_sum[32], booth_sum[32:1]};
          q   <= {booth_sum[0], q[31:1]};
          qm1 <= q[0];
          cnt <= cnt + 6'd1;
        end
        DIV: begin
          if (!trial[33]) begin
            acc <= trial[32:0];
            q   <= {q[30:0], 1'b1};
          end else begin
            acc <= r_sh;
            q   <= {q[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
        end
        FIN: begin
          done <= 1'b1;
          if (!op_r) begin
            zhi_out <= acc[31:0];
            zlo_out <= q;
          end else if (dz) begin
            zhi_out     <= m;
            zlo_out     <= 32'hFFFF_FFFF;
            div_by_zero <= 1'b1;
          end else begin
            zhi_out <= rem;
            zlo_out <= quot;
          end
        end
        default: ;
      endcase
    end
  end

  // Stays high through the done cycle so a caller sees one continuous busy window.
  assign busy = (state != IDLE) || done;

endmodule
